// File: rtl/tri_load_ctrl.sv
// rtl/tri_load_ctrl.sv - sequencer for the serial triangle-load shift register
//
// Frames a triangle on a start pulse, gates the external shift register's
// enable from the serial bit strobe, counts bits to frame completion, then
// captures the parallel word into a 2-entry output queue that feeds the
// rasterizer over a valid/ready handshake.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle pulse beginning a new frame
//   ser_valid     serial bit strobe
//   sh_en         shift enable to the shift register (combinational)
//   sh_clr        registered one-cycle clear to the shift register
//   sh_data       parallel contents of the shift register
//   tri_data      head of the output queue (registered)
//   tri_valid     output queue not empty
//   tri_ready     downstream accepts tri_data
//   busy          sequencer not idle
//   frame_cnt     triangles pushed, wraps silently
//   err_abort     sticky: start arrived mid-frame
//   err_overrun   sticky: strobe arrived while a completed frame was held
//   err_clr       clears both sticky flags
module tri_load_ctrl #(
  parameter int FRAME_BITS = 144,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  ser_valid,
  output logic                  sh_en,
  output logic                  sh_clr,
  input  logic [FRAME_BITS-1:0] sh_data,
  output logic [FRAME_BITS-1:0] tri_data,
  output logic                  tri_valid,
  input  logic                  tri_ready,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic                  err_abort,
  output logic                  err_overrun,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  state_t                  state_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic                    sh_clr_q;
  logic                    err_abort_q;
  logic                    err_overrun_q;

  logic [FRAME_BITS-1:0]   head_q, head_d;
  logic [FRAME_BITS-1:0]   tail_q, tail_d;
  logic [1:0]              count_q, count_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;

  logic                    holding;
  logic                    push;
  logic                    pop;

  // A completed frame sits in the shift register while in LOAD or WAIT.
  assign holding = (state_q == LOAD) || (state_q == WAIT);

  // Eligibility uses the count at cycle start, so a pop from a full queue
  // does not free a slot until the following cycle.
  assign push = holding && (count_q != 2'd2);
  assign pop  = (count_q != 2'd0) && tri_ready;

  // start overrides a coincident strobe: that bit is neither shifted nor counted.
  assign sh_en = (state_q == SHIFT) && ser_valid && !start;

  assign sh_clr      = sh_clr_q;
  assign tri_data    = head_q;
  assign tri_valid   = (count_q != 2'd0);
  assign busy        = (state_q != IDLE);
  assign frame_cnt   = frame_cnt_q;
  assign err_abort   = err_abort_q;
  assign err_overrun = err_overrun_q;

  // Sequencer, bit counter, clear pulse and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      sh_clr_q      <= 1'b0;
      err_abort_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      sh_clr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sh_clr_q  <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (start) begin
            // Abort: restart the frame in place.
            sh_clr_q  <= 1'b1;
            bit_cnt_q <= '0;
          end else if (ser_valid) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= LOAD;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        LOAD: begin
          state_q <= push ? IDLE : WAIT;
        end
        WAIT: begin
          if (push) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // A new error event in the same cycle as err_clr keeps the flag set.
      err_abort_q   <= ((state_q == SHIFT) && start) || (err_abort_q && !err_clr);
      err_overrun_q <= (holding && ser_valid) || (err_overrun_q && !err_clr);
    end
  end

  // Output queue next state. head is the oldest entry, tail the second.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    frame_cnt_d = frame_cnt_q;
    if (push) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = sh_data;
        end else begin
          tail_d = sh_data;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Only reachable with count==1: the new entry becomes the head.
        head_d = sh_data;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 2'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_tri_load_ctrl.sv
// tb/tb_tri_load_ctrl.sv - self-checking bench for tri_load_ctrl
module tb_tri_load_ctrl;

  localparam int FB = 144;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          ser_valid;
  logic          ser_bit;
  logic          sh_en;
  logic          sh_clr;
  logic [FB-1:0] sh_data;
  logic [FB-1:0] tri_data;
  logic          tri_valid;
  logic          tri_ready;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          err_abort;
  logic          err_overrun;
  logic          err_clr;

  int checks   = 0;
  int failures = 0;
  int sh_clr_cnt = 0;

  logic [FB-1:0] sreg = '0;
  logic [FB-1:0] sb[$];

  always #5 clk = ~clk;

  tri_load_ctrl #(.FRAME_BITS(FB), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ser_valid(ser_valid),
    .sh_en(sh_en), .sh_clr(sh_clr), .sh_data(sh_data), .tri_data(tri_data),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .busy(busy),
    .frame_cnt(frame_cnt), .err_abort(err_abort), .err_overrun(err_overrun),
    .err_clr(err_clr)
  );

  // External shift register: serial bit enters at the LSB.
  always @(posedge clk) begin
    if (sh_clr) sreg <= sh_en ? {{(FB-1){1'b0}}, ser_bit} : '0;
    else if (sh_en) sreg <= {sreg[FB-2:0], ser_bit};
  end
  assign sh_data = sreg;

  task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each handshaken triangle against the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && sh_clr) sh_clr_cnt++;
    if (rst_n && tri_valid && tri_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=%0h expected=none", tri_data);
      end else begin
        check("tri_data", tri_data, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Send bits w[FB-1-first] .. downwards, each preceded by gap idle cycles.
  task automatic shift_bits(input logic [FB-1:0] w, input int first, input int n, input int gap);
    for (int i = first; i < first + n; i++) begin
      repeat (gap) tick();
      ser_valid = 1'b1;
      ser_bit   = w[FB-1-i];
      tick();
      ser_valid = 1'b0;
    end
  endtask

  task automatic full_frame(input logic [FB-1:0] w);
    start_pulse();
    shift_bits(w, 0, FB, 0);
    sb.push_back(w);
  endtask

  typedef struct {
    logic [FB-1:0] word;
    int            gap;
    logic [15:0]   exp_cnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [FB-1:0] w, junk;
    int waited;

    rst_n = 1'b0; start = 1'b0; ser_valid = 1'b0; ser_bit = 1'b0;
    tri_ready = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_tri_valid", FB'(tri_valid), FB'(0));
    check("rst_tri_data", tri_data, '0);
    check("rst_busy", FB'(busy), FB'(0));
    check("rst_frame_cnt", FB'(frame_cnt), FB'(0));
    check("rst_errs", FB'({err_abort, err_overrun, sh_clr}), FB'(0));
    rst_n = 1'b1;
    tick();

    vecs[0] = '{word: {9{16'hAAAA}}, gap: 0, exp_cnt: 16'd1};
    vecs[1] = '{word: {$urandom, $urandom, $urandom, $urandom, 16'($urandom)}, gap: 2, exp_cnt: 16'd2};
    vecs[2] = '{word: {FB{1'b1}}, gap: 0, exp_cnt: 16'd3};
    vecs[3] = '{word: {{(FB-1){1'b0}}, 1'b1}, gap: 1, exp_cnt: 16'd4};

    tri_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      start_pulse();
      shift_bits(vecs[v].word, 0, FB, vecs[v].gap);
      sb.push_back(vecs[v].word);
      check("lat_valid_n1", FB'(tri_valid), FB'(0));
      check("lat_busy_load", FB'(busy), FB'(1));
      tick();
      check("lat_valid_n2", FB'(tri_valid), FB'(1));
      check("busy_after_load", FB'(busy), FB'(0));
      repeat (2) tick();
      check("vec_frame_cnt", FB'(frame_cnt), FB'(vecs[v].exp_cnt));
      check("vec_no_err", FB'({err_abort, err_overrun}), FB'(0));
      if (v == 0) check("sh_clr_once", FB'(sh_clr_cnt), FB'(1));
    end

    // Abort at bit 70 with a coincident strobe.
    w    = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    junk = ~w;
    start_pulse();
    shift_bits(junk, 0, 70, 0);
    start = 1'b1; ser_valid = 1'b1; ser_bit = 1'b1;
    #1;
    check("abort_sh_en", FB'(sh_en), FB'(0));
    tick();
    start = 1'b0; ser_valid = 1'b0;
    check("abort_flag", FB'(err_abort), FB'(1));
    check("abort_sh_clr", FB'(sh_clr), FB'(1));
    shift_bits(w, 0, 74, 0);
    repeat (3) tick();
    check("abort_no_push_74", FB'(frame_cnt), FB'(4));
    check("abort_busy_74", FB'(busy), FB'(1));
    shift_bits(w, 74, FB - 74, 0);
    sb.push_back(w);
    repeat (3) tick();
    check("abort_push", FB'(frame_cnt), FB'(5));

    // err_clr coincident with a new abort: the event wins.
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("clr_abort", FB'(err_abort), FB'(0));
    w = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    start_pulse();
    shift_bits(w, 0, 10, 0);
    start = 1'b1; err_clr = 1'b1;
    tick();
    start = 1'b0; err_clr = 1'b0;
    check("clr_vs_abort", FB'(err_abort), FB'(1));
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("clr_alone", FB'(err_abort), FB'(0));
    shift_bits(w, 0, FB, 0);
    sb.push_back(w);
    repeat (3) tick();
    check("clr_frame_cnt", FB'(frame_cnt), FB'(6));

    // Three frames against a stalled consumer, then overrun and drain.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    sb.delete();
    tri_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      full_frame({$urandom, $urandom, $urandom, $urandom, 16'($urandom)});
      repeat (2) tick();
    end
    check("wait_busy", FB'(busy), FB'(1));
    check("wait_valid", FB'(tri_valid), FB'(1));
    check("wait_frame_cnt", FB'(frame_cnt), FB'(2));
    ser_valid = 1'b1; ser_bit = 1'b1; tick(); ser_valid = 1'b0;
    check("overrun_set", FB'(err_overrun), FB'(1));
    tick();
    check("overrun_sticky", FB'(err_overrun), FB'(1));
    tri_ready = 1'b1;
    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      tick();
      waited++;
    end
    check("drain_empty", FB'(sb.size()), FB'(0));
    check("drain_frame_cnt", FB'(frame_cnt), FB'(3));
    check("drain_idle", FB'(busy), FB'(0));

    // Asynchronous reset while holding in WAIT with two queued.
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    tri_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      full_frame({$urandom, $urandom, $urandom, $urandom, 16'($urandom)});
      repeat (2) tick();
    end
    check("pre_rst_busy", FB'(busy), FB'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", FB'(tri_valid), FB'(0));
    check("arst_frame_cnt", FB'(frame_cnt), FB'(0));
    check("arst_idle", FB'(busy), FB'(0));
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tri_load_ctrl.md
Name: tri_load_ctrl

Overview:
- Sequencer for the 144-bit serial triangle-load shift register.
- Frames each triangle on a start pulse and gates the register's shift enable from the serial bit strobe.
- Counts bits to frame completion, then captures the parallel word into a 2-entry output queue.
- Presents triangles to the downstream rasterizer over a valid/ready handshake, and flags framing and overrun errors.

Parameters:
- FRAME_BITS, 144: bits per triangle frame; parallel width of sh_data and tri_data.
- CNT_W, 8: bit-counter width; must satisfy 2^CNT_W > FRAME_BITS.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a new frame.
- ser_valid  in  1  serial bit strobe; the external shift register samples its serial input when sh_en=1.
- sh_en  out  1  shift enable to the shift register (combinational: state==SHIFT && ser_valid).
- sh_clr  out  1  registered one-cycle clear to the shift register.
- sh_data  in  FRAME_BITS  parallel contents of the shift register.
- tri_data  out  FRAME_BITS  head of the output queue.
- tri_valid  out  1  queue not empty.
- tri_ready  in  1  downstream accepts tri_data.
- busy  out  1  state != IDLE.
- frame_cnt  out  16  triangles pushed; wraps 0xFFFF->0.
- err_abort  out  1  sticky: start arrived mid-frame.
- err_overrun  out  1  sticky: ser_valid arrived while a frame was being held.
- err_clr  in  1  clears both sticky flags.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, bit_cnt=0.
  - Queue emptied: tri_valid=0, tri_data=0.
  - sh_clr=0, frame_cnt=0, err_abort=0, err_overrun=0.
  - Reset mid-frame or mid-hold discards everything; no partial push.
- FSM states: IDLE, SHIFT, LOAD, WAIT.
- IDLE:
  - sh_en=0.
  - start=1: sh_clr=1 next cycle, bit_cnt<=0, go to SHIFT.
  - ser_valid in IDLE is ignored; no error.
- SHIFT:
  - Each ser_valid=1 increments bit_cnt.
  - ser_valid with bit_cnt==FRAME_BITS-1 -> LOAD.
  - start=1 in SHIFT (abort): set err_abort, pulse sh_clr, bit_cnt<=0, stay in SHIFT.
  - start overrides a coincident ser_valid; that bit is not counted and sh_en=0 that cycle.
- LOAD (exactly one cycle; sh_data holds the complete frame):
  - Queue count<2: push sh_data, frame_cnt+1, go to IDLE.
  - Queue full: go to WAIT.
- WAIT:
  - Push sh_data on the first cycle the queue count<2 at cycle start, then go to IDLE.
  - sh_data must stay frozen; sh_en=0 guarantees this.
- Errors and start in LOAD/WAIT:
  - ser_valid=1 in LOAD or WAIT sets err_overrun; the bit is dropped.
  - start in LOAD/WAIT is ignored; a new frame cannot begin until IDLE.
- Latency:
  - Last bit sampled at edge N; state=LOAD in cycle N+1; push at edge N+1.
  - tri_valid=1 in cycle N+2 when the queue was empty.
- Queue:
  - 2-entry FIFO; tri_data is a registered head.
  - Pop when tri_valid && tri_ready.
  - Push eligibility uses the count at cycle start: no same-cycle credit from a pop when full.
  - Push and pop in the same cycle with count==1 leaves count==1, head = new entry.
  - Order strictly FIFO.
- Sticky flags:
  - err_clr=1 clears both flags next edge.
  - A new error event in the same cycle as err_clr wins (flag stays 1).
- frame_cnt wraps silently; no flag.

Test Plan:
- Reset then start, 144 ser_valid strobes with alternating pattern, tri_ready=1 -> sh_clr pulses once; tri_valid rises exactly 2 cycles after the last strobe; tri_data=0xAAAA…A; frame_cnt=1; busy low after LOAD.
- Strobes with gaps: ser_valid on every third cycle for 144 bits -> bit_cnt advances only on strobes; one push; no errors.
- tri_ready=0 across three full frames -> first two queue; third holds in WAIT with busy=1; extra ser_valid sets err_overrun=1; raise tri_ready -> three triangles emerge in order; frame_cnt=3.
- start at bit 70 of a frame -> err_abort=1; sh_clr pulses; frame completes 144 strobes after the abort, not 74; exactly one push.
- err_clr asserted in the same cycle as a new abort -> err_abort stays 1; err_clr alone next cycle -> 0.
- rst_n low during WAIT with 2 queued -> tri_valid=0, frame_cnt=0, state IDLE immediately (asynchronous, no clock edge needed).
